// File: rtl/t_b_pkg.sv
// Shared definitions for the temporal-to-binary decoder: FSM states and default sizing.
package t_b_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_NUM_LINES         = 16;
    localparam int DEF_GAMMA_CYCLE_WIDTH = 16;

endpackage

// File: rtl/t_b_lane.sv
// One temporal line: rising-edge detect and first-arrival capture within a gamma cycle.
module t_b_lane #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int CNT_W             = 4,
    parameter int VAL_WIDTH         = 5
) (
    input  logic                 aclk,
    input  logic                 grst,
    input  logic                 run,
    input  logic [CNT_W-1:0]     cnt,
    input  logic                 t_in,
    output logic [VAL_WIDTH-1:0] value
);

    logic             prev;
    logic             got;
    logic [CNT_W-1:0] cap;
    logic             first;
    logic             prev_eff;
    logic             got_eff;
    logic             hit;

    // Counter 0 opens a new gamma cycle: history from the previous one is ignored.
    assign first    = (cnt == '0);
    assign prev_eff = prev && !first;
    assign got_eff  = got && !first;
    assign hit      = run && t_in && !prev_eff && !got_eff;

    // Includes an arrival in the current cycle so the G-1 sample is counted.
    assign value = hit     ? VAL_WIDTH'(cnt) :
                   got_eff ? VAL_WIDTH'(cap) :
                             VAL_WIDTH'(GAMMA_CYCLE_WIDTH);

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            prev <= 1'b0;
            got  <= 1'b0;
            cap  <= '0;
        end else if (!run) begin
            prev <= 1'b0;
            got  <= 1'b0;
        end else begin
            prev <= t_in;
            got  <= got_eff || hit;
            if (hit) begin
                cap <= cnt;
            end
        end
    end

endmodule

// File: rtl/t_b_decoder.sv
// Temporal-to-binary decoder: converts per-line spike arrival times within a gamma cycle to values.
module t_b_decoder
    import t_b_pkg::*;
#(
    parameter int  NUM_LINES         = DEF_NUM_LINES,
    parameter int  GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
    localparam int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                           aclk,
    input  logic                           grst,
    input  logic                           en,
    input  logic [NUM_LINES-1:0]           t_in,
    output logic                           gamma_start,
    output logic [NUM_LINES*VAL_WIDTH-1:0] out_values,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overrun
);

    localparam int               CNT_W = (VAL_WIDTH > 1) ? VAL_WIDTH - 1 : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(GAMMA_CYCLE_WIDTH - 1);

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic                           run;
    logic                           load;
    logic [NUM_LINES*VAL_WIDTH-1:0] lane_values;

    // A cycle with en low is not processed, so a dropped enable never produces a load.
    assign run  = (state == RUN) && en;
    assign load = run && (cnt == LAST);

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_lane
        t_b_lane #(
            .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
            .CNT_W            (CNT_W),
            .VAL_WIDTH        (VAL_WIDTH)
        ) u_lane (
            .aclk (aclk),
            .grst (grst),
            .run  (run),
            .cnt  (cnt),
            .t_in (t_in[g]),
            .value(lane_values[g*VAL_WIDTH +: VAL_WIDTH])
        );
    end

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state       <= IDLE;
            cnt         <= '0;
            gamma_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    gamma_start <= en;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        gamma_start <= 1'b0;
                    end else begin
                        cnt         <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                        gamma_start <= (cnt == LAST);
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    gamma_start <= 1'b0;
                end
            endcase
        end
    end

    // A load coinciding with a transfer is a clean hand-over, not an overrun.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            out_values <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            out_values <= lane_values;
            out_valid  <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_t_b_decoder.sv
// Bench for t_b_decoder: directed scenarios plus random traffic against an arrival-time model.
module tb_t_b_decoder;

    localparam int NL = 16;
    localparam int G  = 16;
    localparam int VW = $clog2(G) + 1;

    logic           aclk = 1'b0;
    logic           grst;
    logic           en;
    logic [NL-1:0]  t_in;
    logic           gamma_start;
    logic [NL*VW-1:0] out_values;
    logic           out_valid;
    logic           out_ready;
    logic           overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: whole gamma cycles of samples are kept, then reduced to arrival times.
    bit            m_run;
    int            m_cnt;
    logic [NL-1:0] samp [G];
    int            exp_vals [NL];
    bit            exp_valid;
    bit            exp_ovr;

    always #5 aclk = ~aclk;

    t_b_decoder #(
        .NUM_LINES        (NL),
        .GAMMA_CYCLE_WIDTH(G)
    ) dut (
        .aclk       (aclk),
        .grst       (grst),
        .en         (en),
        .t_in       (t_in),
        .gamma_start(gamma_start),
        .out_values (out_values),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int arrival(input int line);
        for (int t = 0; t < G; t++) begin
            logic prv;
            prv = (t == 0) ? 1'b0 : samp[t-1][line];
            if (samp[t][line] && !prv) return t;
        end
        return G;
    endfunction

    function automatic logic [NL*VW-1:0] exp_pack();
        logic [NL*VW-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*VW +: VW] = VW'(exp_vals[i]);
        return v;
    endfunction

    function automatic int dval(input int line);
        return int'(out_values[line*VW +: VW]);
    endfunction

    task automatic model_reset();
        m_run     = 1'b0;
        m_cnt     = 0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        for (int i = 0; i < NL; i++) exp_vals[i] = 0;
    endtask

    task automatic model_step();
        bit xfer;
        xfer = exp_valid && out_ready;
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_cnt = 0;
            end
        end else if (!en) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else begin
            samp[m_cnt] = t_in;
            if (m_cnt == G - 1) begin
                if (exp_valid && !out_ready) exp_ovr = 1'b1;
                for (int i = 0; i < NL; i++) exp_vals[i] = arrival(i);
                exp_valid = 1'b1;
                xfer      = 1'b0;
            end
            m_cnt = (m_cnt + 1) % G;
        end
        if (xfer) exp_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge aclk);
        if (!grst) model_step();
        #1;
        check("gamma_start", gamma_start, m_run && (m_cnt == 0));
        check("out_valid", out_valid, exp_valid);
        check("overrun", overrun, exp_ovr);
        check("out_values", out_values, exp_pack());
    endtask

    task automatic do_reset();
        grst = 1'b1;
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_out_values", out_values, '0);
        check("rst_gamma_start", gamma_start, 1'b0);
        @(negedge aclk);
        grst = 1'b0;
    endtask

    task automatic start(input logic rdy);
        en        = 1'b0;
        t_in      = '0;
        out_ready = rdy;
        do_reset();
        en = 1'b1;
        tick();
    endtask

    task automatic goto(input int k);
        int b;
        b = 0;
        while (!m_run || m_cnt != k) begin
            tick();
            b++;
            if (b > 2 * G) begin
                n_checks++;
                n_fail++;
                $display("FAIL goto: counter %0d not reached within %0d cycles", k, b);
                return;
            end
        end
    endtask

    task automatic end_gamma();
        goto(G - 1);
        tick();
    endtask

    initial begin
        grst      = 1'b1;
        en        = 1'b0;
        t_in      = '0;
        out_ready = 1'b0;
        model_reset();

        // Two lines rising at different counters, then lines held across boundaries
        start(1'b0);
        t_in = 16'h0080;
        goto(5);
        t_in[3] = 1'b1;
        end_gamma();
        check("t1_valid", out_valid, 1'b1);
        check("t1_v3", dval(3), 5);
        check("t1_v7", dval(7), 0);
        check("t1_v0", dval(0), G);
        check("t1_v15", dval(15), G);
        out_ready = 1'b1;
        goto(10);
        t_in[0] = 1'b1;
        end_gamma();
        check("t5_v0_rise", dval(0), 10);
        check("t5_v3_held", dval(3), 0);
        end_gamma();
        check("t5_v0_held", dval(0), 0);

        // Only the first edge in a gamma cycle counts
        start(1'b1);
        goto(4);
        t_in = 16'h0004;
        goto(6);
        t_in = '0;
        goto(9);
        t_in = 16'h0004;
        end_gamma();
        check("t2_v2", dval(2), 4);

        // Overrun when a result is overwritten unconsumed
        start(1'b0);
        goto(3);
        t_in = 16'h0002;
        goto(5);
        t_in = '0;
        end_gamma();
        check("t3_ovr_first", overrun, 1'b0);
        check("t3_v1_first", dval(1), 3);
        goto(8);
        t_in = 16'h0002;
        end_gamma();
        check("t3_ovr_set", overrun, 1'b1);
        check("t3_v1_second", dval(1), 8);
        out_ready = 1'b1;
        tick();
        check("t3_valid_drop", out_valid, 1'b0);
        check("t3_ovr_sticky", overrun, 1'b1);

        // Transfer in the same cycle as the next load
        start(1'b0);
        goto(3);
        t_in = 16'h0002;
        goto(4);
        t_in = '0;
        end_gamma();
        goto(G - 1);
        out_ready = 1'b1;
        tick();
        check("t3b_ovr", overrun, 1'b0);
        check("t3b_valid", out_valid, 1'b1);
        check("t3b_v1", dval(1), G);

        // Enable dropped mid-gamma, then asynchronous reset with a result pending
        start(1'b0);
        goto(2);
        t_in = 16'h0010;
        end_gamma();
        check("t4_v4", dval(4), 2);
        t_in = '0;
        goto(3);
        t_in = 16'h0020;
        goto(8);
        en = 1'b0;
        repeat (6) tick();
        check("t4_valid_kept", out_valid, 1'b1);
        check("t4_v4_kept", dval(4), 2);
        check("t4_v5_none", dval(5), G);
        check("t4_gs_idle", gamma_start, 1'b0);
        en = 1'b1;
        tick();
        check("t4_gs_resume", gamma_start, 1'b1);
        end_gamma();
        check("t4_ovr", overrun, 1'b1);
        goto(6);
        check("t6_valid_before", out_valid, 1'b1);
        do_reset();

        // Random traffic against the model
        start(1'b1);
        for (int c = 0; c < 1200; c++) begin
            en        = ($urandom_range(0, 63) != 0);
            t_in      = t_in ^ NL'($urandom & $urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
